// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue sequencer: ALU op codes, MIPS opcode/funct
// values, writeback kinds and the sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] ALUOP_ADD = 3'd0;
  localparam logic [2:0] ALUOP_SUB = 3'd1;
  localparam logic [2:0] ALUOP_AND = 3'd2;
  localparam logic [2:0] ALUOP_OR  = 3'd3;
  localparam logic [2:0] ALUOP_SLT = 3'd4;
  localparam logic [2:0] ALUOP_NOR = 3'd5;
  localparam logic [2:0] ALUOP_SLL = 3'd6;
  localparam logic [2:0] ALUOP_SRL = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  localparam logic [1:0] KIND_NONE     = 2'd0;
  localparam logic [1:0] KIND_REG_WB   = 2'd1;
  localparam logic [1:0] KIND_MEM_ADDR = 2'd2;
  localparam logic [1:0] KIND_BRANCH   = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StExec,
    StCapt,
    StDone
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of (opcode, funct) into ALU control, operand routing and
// writeback kind for the issue sequencer.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic       o_src2_is_imm,
  output logic       o_use_shamt,
  output logic [1:0] o_kind,
  output logic       o_is_bne,
  output logic       o_illegal
);

  always_comb begin
    o_alu_op      = ALUOP_ADD;
    o_src2_is_imm = 1'b0;
    o_use_shamt   = 1'b0;
    o_kind        = KIND_NONE;
    o_is_bne      = 1'b0;
    o_illegal     = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_kind = KIND_REG_WB;
        case (i_funct)
          FN_ADD: o_alu_op = ALUOP_ADD;
          FN_SUB: o_alu_op = ALUOP_SUB;
          FN_AND: o_alu_op = ALUOP_AND;
          FN_OR:  o_alu_op = ALUOP_OR;
          FN_SLT: o_alu_op = ALUOP_SLT;
          FN_NOR: o_alu_op = ALUOP_NOR;
          FN_SLL: begin
            o_alu_op    = ALUOP_SLL;
            o_use_shamt = 1'b1;
          end
          FN_SRL: begin
            o_alu_op    = ALUOP_SRL;
            o_use_shamt = 1'b1;
          end
          default: begin
            o_kind    = KIND_NONE;
            o_illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        o_src2_is_imm = 1'b1;
        o_kind        = KIND_REG_WB;
      end
      OP_LW, OP_SW: begin
        o_src2_is_imm = 1'b1;
        o_kind        = KIND_MEM_ADDR;
      end
      OP_BEQ, OP_BNE: begin
        o_alu_op = ALUOP_SUB;
        o_kind   = KIND_BRANCH;
        o_is_bne = (i_opcode == OP_BNE);
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of a 32-bit combinational ALU: accepts one instruction,
// sequences shamt then operands into the ALU, samples the result and holds it.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [5:0]        i_opcode,
  input  logic [5:0]        i_funct,
  input  logic [4:0]        i_shamt_in,
  input  logic [DATA_W-1:0] i_rs_val,
  input  logic [DATA_W-1:0] i_rt_val,
  input  logic [15:0]       i_imm,
  input  logic [DATA_W-1:0] i_pc_plus4,
  output logic [DATA_W-1:0] o_alu_in1,
  output logic [DATA_W-1:0] o_alu_in2,
  output logic [2:0]        o_alu_op,
  output logic [4:0]        o_alu_shamt,
  input  logic [DATA_W-1:0] i_alu_res,
  input  logic              i_alu_zero,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_result,
  output logic [1:0]        o_out_kind,
  output logic              o_out_taken,
  output logic [DATA_W-1:0] o_out_target,
  output logic              o_out_illegal
);

  localparam logic [2:0] LastCnt = 3'(SETTLE_CYCLES);

  state_e            r_state;
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] r_lat_in1, r_lat_in2, r_lat_pc4;
  logic [2:0]        r_lat_op;
  logic [4:0]        r_lat_shamt;
  logic [1:0]        r_lat_kind;
  logic              r_lat_is_bne;
  logic [15:0]       r_lat_imm;
  logic [DATA_W-1:0] r_alu_in1, r_alu_in2, r_out_result, r_out_target;
  logic [2:0]        r_alu_op;
  logic [4:0]        r_alu_shamt;
  logic              r_out_valid, r_out_taken, r_out_illegal;
  logic [1:0]        r_out_kind;

  logic [2:0]        w_dec_op;
  logic              w_dec_src2_imm, w_dec_use_shamt, w_dec_is_bne, w_dec_illegal;
  logic [1:0]        w_dec_kind;
  logic [DATA_W-1:0] w_sext_imm, w_in1, w_in2, w_target;
  logic              w_taken, w_is_branch;

  alu_op_decode u_decode (
    .i_opcode      (i_opcode),
    .i_funct       (i_funct),
    .o_alu_op      (w_dec_op),
    .o_src2_is_imm (w_dec_src2_imm),
    .o_use_shamt   (w_dec_use_shamt),
    .o_kind        (w_dec_kind),
    .o_is_bne      (w_dec_is_bne),
    .o_illegal     (w_dec_illegal)
  );

  // Shifts take their operand from rt on in1; everything else is rs on in1.
  assign w_sext_imm  = {{(DATA_W-16){i_imm[15]}}, i_imm};
  assign w_in1       = w_dec_use_shamt ? i_rt_val : i_rs_val;
  assign w_in2       = w_dec_src2_imm ? w_sext_imm : i_rt_val;
  assign w_target    = r_lat_pc4 + {{(DATA_W-18){r_lat_imm[15]}}, r_lat_imm, 2'b00};
  assign w_taken     = r_lat_is_bne ? ~i_alu_zero : i_alu_zero;
  assign w_is_branch = (r_lat_kind == KIND_BRANCH);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_lat_in1     <= '0;
      r_lat_in2     <= '0;
      r_lat_pc4     <= '0;
      r_lat_op      <= '0;
      r_lat_shamt   <= '0;
      r_lat_kind    <= KIND_NONE;
      r_lat_is_bne  <= 1'b0;
      r_lat_imm     <= '0;
      r_alu_in1     <= '0;
      r_alu_in2     <= '0;
      r_alu_op      <= '0;
      r_alu_shamt   <= '0;
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_kind    <= KIND_NONE;
      r_out_taken   <= 1'b0;
      r_out_target  <= '0;
      r_out_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            r_lat_in1    <= w_in1;
            r_lat_in2    <= w_in2;
            r_lat_op     <= w_dec_op;
            r_lat_shamt  <= w_dec_use_shamt ? i_shamt_in : 5'd0;
            r_lat_kind   <= w_dec_kind;
            r_lat_is_bne <= w_dec_is_bne;
            r_lat_imm    <= i_imm;
            r_lat_pc4    <= i_pc_plus4;
            if (w_dec_illegal) begin
              // Illegal instructions never touch the ALU.
              r_state       <= StDone;
              r_out_valid   <= 1'b1;
              r_out_result  <= '0;
              r_out_kind    <= KIND_NONE;
              r_out_taken   <= 1'b0;
              r_out_target  <= '0;
              r_out_illegal <= 1'b1;
            end else begin
              r_state <= StSetup;
            end
          end
        end
        StSetup: begin
          // The ALU ignores shamt-only changes, so shamt settles first.
          r_alu_shamt <= r_lat_shamt;
          r_state     <= StExec;
        end
        StExec: begin
          r_alu_in1 <= r_lat_in1;
          r_alu_in2 <= r_lat_in2;
          r_alu_op  <= r_lat_op;
          r_cnt     <= '0;
          r_state   <= StCapt;
        end
        StCapt: begin
          if (r_cnt == LastCnt) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= i_alu_res;
            r_out_kind    <= r_lat_kind;
            r_out_taken   <= w_is_branch & w_taken;
            r_out_target  <= w_is_branch ? w_target : '0;
            r_out_illegal <= 1'b0;
            r_state       <= StDone;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        StDone: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_in_ready    = (r_state == StIdle);
  assign o_alu_in1     = r_alu_in1;
  assign o_alu_in2     = r_alu_in2;
  assign o_alu_op      = r_alu_op;
  assign o_alu_shamt   = r_alu_shamt;
  assign o_out_valid   = r_out_valid;
  assign o_out_result  = r_out_result;
  assign o_out_kind    = r_out_kind;
  assign o_out_taken   = r_out_taken;
  assign o_out_target  = r_out_target;
  assign o_out_illegal = r_out_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, instruction-level reference model,
// per-cycle compare, directed literal cases and randomized traffic.
module tb_alu_issue_ctrl;

  localparam int unsigned S   = 1;
  localparam int          LAT = 3 + S;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, alu_zero;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt_in;
  logic [31:0] rs_val, rt_val, pc_plus4, alu_res;
  logic [15:0] imm;
  logic        in_ready, out_valid, out_taken, out_illegal;
  logic [31:0] alu_in1, alu_in2, out_result, out_target;
  logic [2:0]  alu_op;
  logic [4:0]  alu_shamt;
  logic [1:0]  out_kind;

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_ready = 1'b0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(32), .SETTLE_CYCLES(S)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_opcode      (opcode),
    .i_funct       (funct),
    .i_shamt_in    (shamt_in),
    .i_rs_val      (rs_val),
    .i_rt_val      (rt_val),
    .i_imm         (imm),
    .i_pc_plus4    (pc_plus4),
    .o_alu_in1     (alu_in1),
    .o_alu_in2     (alu_in2),
    .o_alu_op      (alu_op),
    .o_alu_shamt   (alu_shamt),
    .i_alu_res     (alu_res),
    .i_alu_zero    (alu_zero),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_result  (out_result),
    .o_out_kind    (out_kind),
    .o_out_taken   (out_taken),
    .o_out_target  (out_target),
    .o_out_illegal (out_illegal)
  );

  // Stand-in for the external combinational ALU.
  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      3'd0: alu_res = alu_in1 + alu_in2;
      3'd1: alu_res = alu_in1 - alu_in2;
      3'd2: alu_res = alu_in1 & alu_in2;
      3'd3: alu_res = alu_in1 | alu_in2;
      3'd4: alu_res = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
      3'd5: alu_res = ~(alu_in1 | alu_in2);
      3'd6: alu_res = alu_in1 << alu_shamt;
      default: alu_res = alu_in1 >> alu_shamt;
    endcase
    alu_zero = (alu_in1 == alu_in2);
  end

  typedef struct {
    logic        ill;
    logic [1:0]  kind;
    logic [31:0] res, tgt, in1, in2;
    logic        taken;
    logic [2:0]  op;
    logic [4:0]  sh;
    logic        sh_known;
  } exp_t;

  function automatic exp_t model(input logic [5:0] opc, input logic [5:0] fn,
                                 input logic [4:0] sh, input logic [31:0] rs,
                                 input logic [31:0] rt, input logic [15:0] im,
                                 input logic [31:0] pc4);
    exp_t e;
    logic [31:0] sx;
    sx = {{16{im[15]}}, im};
    e.ill = 1'b0; e.kind = 2'd1; e.res = 32'd0; e.tgt = 32'd0; e.taken = 1'b0;
    e.in1 = rs; e.in2 = rt; e.op = 3'd0; e.sh = 5'd0; e.sh_known = 1'b0;
    if (opc == 6'h00) begin
      case (fn)
        6'h20: begin e.op = 3'd0; e.res = rs + rt; end
        6'h22: begin e.op = 3'd1; e.res = rs - rt; end
        6'h24: begin e.op = 3'd2; e.res = rs & rt; end
        6'h25: begin e.op = 3'd3; e.res = rs | rt; end
        6'h2A: begin e.op = 3'd4; e.res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0; end
        6'h27: begin e.op = 3'd5; e.res = ~(rs | rt); end
        6'h00: begin e.op = 3'd6; e.in1 = rt; e.res = rt << sh; e.sh = sh; e.sh_known = 1'b1; end
        6'h02: begin e.op = 3'd7; e.in1 = rt; e.res = rt >> sh; e.sh = sh; e.sh_known = 1'b1; end
        default: e.ill = 1'b1;
      endcase
    end else if (opc == 6'h08) begin
      e.in2 = sx; e.res = rs + sx;
    end else if (opc == 6'h23 || opc == 6'h2B) begin
      e.kind = 2'd2; e.in2 = sx; e.res = rs + sx;
    end else if (opc == 6'h04 || opc == 6'h05) begin
      e.kind = 2'd3; e.op = 3'd1; e.res = rs - rt;
      e.taken = (opc == 6'h04) ? (rs == rt) : (rs != rt);
      e.tgt = pc4 + (sx << 2);
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) e.kind = 2'd0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: one instruction in flight, timed in edges since accept.
  bit          m_live = 1'b0;
  bit          m_valid = 1'b0;
  int          m_rem = 0;
  exp_t        m_pend, m_out;
  logic [31:0] m_in1, m_in2;
  logic [2:0]  m_op;
  logic [4:0]  m_sh;
  bit          m_sh_known;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_live = 1'b1; m_valid = 1'b0; m_rem = 0;
        m_in1 = 32'd0; m_in2 = 32'd0; m_op = 3'd0; m_sh = 5'd0; m_sh_known = 1'b1;
      end else if (!m_live) begin
        m_rem = 0;
      end else if (m_valid) begin
        if (out_ready) m_valid = 1'b0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == LAT - 1) begin m_sh = m_pend.sh; m_sh_known = m_pend.sh_known; end
        if (m_rem == LAT - 2) begin m_in1 = m_pend.in1; m_in2 = m_pend.in2; m_op = m_pend.op; end
        if (m_rem == 0) begin m_valid = 1'b1; m_out = m_pend; end
      end else if (in_valid) begin
        m_pend = model(opcode, funct, shamt_in, rs_val, rt_val, imm, pc_plus4);
        if (m_pend.ill) begin m_valid = 1'b1; m_out = m_pend; end
        else m_rem = LAT;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live && !rst) begin
        check("in_ready", 32'(in_ready), 32'(!m_valid && m_rem == 0));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("alu_in1", alu_in1, m_in1);
        check("alu_in2", alu_in2, m_in2);
        check("alu_op", 32'(alu_op), 32'(m_op));
        if (m_sh_known) check("alu_shamt", 32'(alu_shamt), 32'(m_sh));
        if (m_valid) begin
          check("out_kind", 32'(out_kind), 32'(m_out.kind));
          check("out_illegal", 32'(out_illegal), 32'(m_out.ill));
          check("out_taken", 32'(out_taken), 32'(m_out.taken));
          check("out_target", out_target, m_out.tgt);
          if (!m_out.ill) check("out_result", out_result, m_out.res);
        end
      end
    end
  end

  task automatic scramble();
    opcode = 6'($urandom); funct = 6'($urandom); shamt_in = 5'($urandom);
    rs_val = $urandom; rt_val = $urandom; imm = 16'($urandom); pc_plus4 = $urandom;
  endtask

  task automatic issue(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                       input logic [31:0] pc4);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
    check("issue wait in_ready", 32'(in_ready), 32'd1);
    opcode = opc; funct = fn; shamt_in = sh; rs_val = rs; rt_val = rt; imm = im;
    pc_plus4 = pc4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait out_valid", 32'(out_valid), 32'd1);
  endtask

  logic [5:0] opc_tab[10];
  logic [5:0] fn_tab[9];

  initial begin
    opc_tab[0] = 6'h00; opc_tab[1] = 6'h00; opc_tab[2] = 6'h00; opc_tab[3] = 6'h08;
    opc_tab[4] = 6'h23; opc_tab[5] = 6'h2B; opc_tab[6] = 6'h04; opc_tab[7] = 6'h05;
    opc_tab[8] = 6'h3F; opc_tab[9] = 6'h00;
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25;
    fn_tab[4] = 6'h2A; fn_tab[5] = 6'h27; fn_tab[6] = 6'h00; fn_tab[7] = 6'h02;
    fn_tab[8] = 6'h00;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; funct = '0; shamt_in = '0; rs_val = '0; rt_val = '0; imm = '0; pc_plus4 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset alu_in1", alu_in1, 32'd0);

    // add 5+5: exact latency of LAT edges
    issue(6'h00, 6'h20, 5'd0, 32'd5, 32'd5, 16'd0, 32'd0);
    repeat (LAT - 1) @(posedge clk);
    #1 check("add early valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("add valid", 32'(out_valid), 32'd1);
    check("add result", out_result, 32'd10);
    check("add kind", 32'(out_kind), 32'd1);
    check("add illegal", 32'(out_illegal), 32'd0);

    issue(6'h04, 6'h00, 5'd0, 32'd7, 32'd7, 16'hFFFF, 32'h100);
    wait_valid();
    check("beq taken", 32'(out_taken), 32'd1);
    check("beq target", out_target, 32'h0000_00FC);
    check("beq kind", 32'(out_kind), 32'd3);

    issue(6'h05, 6'h00, 5'd0, 32'd7, 32'd7, 16'hFFFF, 32'h100);
    wait_valid();
    check("bne taken", 32'(out_taken), 32'd0);
    check("bne target", out_target, 32'h0000_00FC);

    // sll: shamt moves one edge before alu_op
    issue(6'h00, 6'h00, 5'd4, 32'h55, 32'h1, 16'd0, 32'd0);
    @(posedge clk); #1;
    check("sll shamt first", 32'(alu_shamt), 32'd4);
    check("sll op still old", 32'(alu_op), 32'd1);
    @(posedge clk); #1;
    check("sll op", 32'(alu_op), 32'd6);
    wait_valid();
    check("sll result", out_result, 32'h10);

    issue(6'h23, 6'h00, 5'd0, 32'h1000, 32'h0, 16'h8004, 32'd0);
    wait_valid();
    check("lw result", out_result, 32'hFFFF_9004);
    check("lw kind", 32'(out_kind), 32'd2);

    // illegal: valid right after accept, ALU untouched
    issue(6'h3F, 6'h00, 5'd0, 32'h1234, 32'h5678, 16'h0, 32'd0);
    check("illegal valid", 32'(out_valid), 32'd1);
    check("illegal flag", 32'(out_illegal), 32'd1);
    check("illegal kind", 32'(out_kind), 32'd0);
    check("illegal alu_in1 kept", alu_in1, 32'h1000);
    check("illegal alu_in2 kept", alu_in2, 32'hFFFF_8004);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk); #1;

    // backpressure with a competing in_valid held high
    out_ready = 1'b0;
    issue(6'h00, 6'h20, 5'd0, 32'd3, 32'd4, 16'd0, 32'd0);
    wait_valid();
    opcode = 6'h00; funct = 6'h20; in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("bp valid held", 32'(out_valid), 32'd1);
    check("bp in_ready", 32'(in_ready), 32'd0);
    check("bp result", out_result, 32'd7);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release no accept", 32'(in_ready), 32'd1);
    check("release valid drop", 32'(out_valid), 32'd0);
    in_valid = 1'b0;

    // reset in EXEC discards the instruction
    issue(6'h00, 6'h22, 5'd0, 32'd9, 32'd2, 16'd0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst mid valid", 32'(out_valid), 32'd0);
    check("rst mid in_ready", 32'(in_ready), 32'd1);
    check("rst mid alu_in1", alu_in1, 32'd0);
    repeat (6) @(posedge clk);
    #1;

    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [5:0]  r_opc, r_fn;
      logic [31:0] r_rs, r_rt;
      r_opc = opc_tab[$urandom_range(0, 9)];
      r_fn  = fn_tab[$urandom_range(0, 8)];
      if ($urandom_range(0, 7) == 0) r_fn = 6'($urandom);
      r_rs = $urandom;
      r_rt = ($urandom_range(0, 3) == 0) ? r_rs : $urandom;
      if ($urandom_range(0, 3) == 0) r_rs = 32'($urandom_range(0, 15));
      issue(r_opc, r_fn, 5'($urandom), r_rs, r_rt, 16'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("final idle", 32'(in_ready), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
